frame_sequencer: RTL

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: loads core weights once per run, then streams FRAME_WORDS
// input words per frame into the core and forwards each frame's result to the
// output FIFO until num_frames results have been collected.
// Optional: define FRAME_SEQ_TIMEOUT_EN for a DRAIN watchdog (TIMEOUT_CYC).
module frame_sequencer #(
    parameter int FRAME_WORDS = 784,
    parameter int OUT_W       = 10,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      num_frames,
    input  logic             in_empty,
    output logic             in_rd_en,
    output logic             core_load,
    input  logic             load_weight_done,
    output logic             core_input_valid,
    output logic             core_sof,
    input  logic             core_output_valid,
    input  logic [OUT_W-1:0] core_d_out,
    input  logic             out_full,
    output logic             out_wr_en,
    output logic [OUT_W-1:0] out_din,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             timeout,
    output logic [15:0]      frames_done
);

    localparam int CW = $clog2(FRAME_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT_W, S_STREAM, S_DRAIN, S_FINISH
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] word_cnt;
    logic [15:0]   num_q;
    logic [15:0]   fd_inc;
    logic          accept;
    logic          result;
    logic          more;
    logic          wd_hit;

    assign accept  = (state == S_IDLE) && start;
    assign result  = (state == S_DRAIN) && core_output_valid;
    assign fd_inc  = frames_done + 16'd1;
    assign more    = fd_inc < num_q;
    assign busy    = (state != S_IDLE);
    assign out_din = core_d_out;

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] drain_cnt;

    assign wd_hit = (state == S_DRAIN) && !core_output_valid &&
                    (drain_cnt == TW'(TIMEOUT_CYC - 1));

    // Watchdog: counts cycles spent in DRAIN, restarts on every DRAIN entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt <= '0;
            timeout   <= 1'b0;
        end else begin
            drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
            if (accept)
                timeout <= 1'b0;
            else if (wd_hit)
                timeout <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC == 0);
    assign wd_hit     = 1'b0;
    assign timeout    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state and strobe outputs; reads stop once the frame's words are issued
    always_comb begin
        state_nx  = state;
        in_rd_en  = 1'b0;
        core_load = 1'b0;
        out_wr_en = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_frames != 16'd0) state_nx = S_LOAD;
                    else                     done     = 1'b1;
                end
            end
            S_LOAD: begin
                core_load = 1'b1;
                state_nx  = S_WAIT_W;
            end
            S_WAIT_W: begin
                if (load_weight_done) state_nx = S_STREAM;
            end
            S_STREAM: begin
                in_rd_en = !in_empty && (word_cnt < CW'(FRAME_WORDS));
                if (in_rd_en && (word_cnt == CW'(FRAME_WORDS - 1)))
                    state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (core_output_valid) begin
                    out_wr_en = !out_full;
                    state_nx  = more ? S_STREAM : S_FINISH;
                end else if (wd_hit) begin
                    state_nx = S_FINISH;
                end
            end
            S_FINISH: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Run bookkeeping: word/frame counters, sampled frame count, sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt    <= '0;
            num_q       <= '0;
            frames_done <= '0;
            overflow    <= 1'b0;
        end else begin
            if (accept) begin
                word_cnt    <= '0;
                num_q       <= num_frames;
                frames_done <= '0;
                overflow    <= 1'b0;
            end
            if (in_rd_en)
                word_cnt <= word_cnt + 1'b1;
            if (result) begin
                frames_done <= fd_inc;
                word_cnt    <= '0;
                if (out_full) overflow <= 1'b1;
            end
        end
    end

    // FIFO data lands one cycle after the read, so valid/sof are the read delayed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_input_valid <= 1'b0;
            core_sof         <= 1'b0;
        end else begin
            core_input_valid <= in_rd_en;
            core_sof         <= in_rd_en && (word_cnt == '0);
        end
    end

endmodule
